// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

    // MUL is treated as unsigned: the low half of the product does not depend on signedness.
    function automatic logic a_signed(input op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic b_signed(input op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used as abs() on operands and as sign correction on results.
module muldiv_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic            neg,
    input  logic [XLEN-1:0] val,
    output logic [XLEN-1:0] res
);

    assign res = neg ? (~val + XLEN'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes, sign fixed on the last step.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit SHORT_CIRCUIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int            CW   = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_e          state, state_nxt;
    op_e             op_in, op_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, opnd;
    logic            sa_q, neg_q, bz_q;

    logic            accept, in_div, in_rem, b_zero, ovf, sc_hit, sa, sb;
    logic [XLEN-1:0] sc_res, mag_a, mag_b;

    assign op_in     = op_e'(op);
    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign in_div = is_div(op_in);
    assign in_rem = in_div && op[1];
    assign b_zero = (src_b == '0);
    assign ovf    = in_div && !op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign sc_hit = in_div ? (b_zero || ovf) : ((src_a == '0) || b_zero);
    assign sa     = a_signed(op_in) & src_a[XLEN-1];
    assign sb     = b_signed(op_in) & src_b[XLEN-1];

    always_comb begin
        sc_res = '0;
        if (in_div && b_zero) begin
            sc_res = in_rem ? src_a : '1;
        end else if (ovf) begin
            sc_res = in_rem ? '0 : src_a;
        end
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_abs_a (.neg(sa), .val(src_a), .res(mag_a));
    muldiv_sign_fix #(.XLEN(XLEN)) u_abs_b (.neg(sb), .val(src_b), .res(mag_b));

    // One iteration: multiply shifts the product right into lo, divide shifts the quotient left into lo.
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN-1:0] div_diff, hi_n, lo_n;
    logic            div_ge;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, opnd});
        div_diff = div_sh[XLEN-1:0] - opnd;
        if (is_div(op_q)) begin
            hi_n = div_ge ? div_diff : div_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remv, res_fin;

    muldiv_sign_fix #(.XLEN(2*XLEN)) u_fix_prod (.neg(neg_q), .val({hi_n, lo_n}), .res(prod));
    // A zero divisor must leave the all-ones quotient untouched even for a negative dividend.
    muldiv_sign_fix #(.XLEN(XLEN)) u_fix_quo (.neg(neg_q & ~bz_q), .val(lo_n), .res(quo));
    muldiv_sign_fix #(.XLEN(XLEN)) u_fix_rem (.neg(sa_q), .val(hi_n), .res(remv));

    always_comb begin
        res_fin = quo;
        case (op_q)
            MUL:                 res_fin = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: res_fin = prod[2*XLEN-1:XLEN];
            REM, REMU:           res_fin = remv;
            default:             res_fin = quo;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (SHORT_CIRCUIT && sc_hit) ? DONE : BUSY;
            BUSY: begin
                if (flush)            state_nxt = IDLE;
                else if (cnt == LAST) state_nxt = DONE;
            end
            DONE: if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
                if (SHORT_CIRCUIT && sc_hit) begin
                    result <= sc_res;
                    rd_out <= rd_in;
                end
            end else if (state == BUSY && !flush) begin
                cnt <= cnt + CW'(1);
                if (cnt == LAST) begin
                    result <= res_fin;
                    rd_out <= rd_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_in;
            sa_q  <= sa;
            neg_q <= sa ^ sb;
            bz_q  <= b_zero;
            hi    <= '0;
            lo    <= in_div ? mag_a : mag_b;
            opnd  <= in_div ? mag_b : mag_a;
        end else if (state == BUSY) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: unit 0 short-circuits special cases, unit 1 always iterates.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [2:0]  op        [2];
    logic [31:0] src_a     [2];
    logic [31:0] src_b     [2];
    logic [4:0]  rd_in     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];
    logic [4:0]  rd_out    [2];
    logic        busy      [2];

    int total = 0;
    int bad   = 0;
    logic [36:0] q0[$];
    logic [36:0] q1[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .SHORT_CIRCUIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .src_a(src_a[0]), .src_b(src_b[0]), .rd_in(rd_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(result[0]), .rd_out(rd_out[0]), .busy(busy[0])
    );

    muldiv_unit #(.XLEN(32), .SHORT_CIRCUIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .src_a(src_a[1]), .src_b(src_b[1]), .rd_in(rd_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(result[1]), .rd_out(rd_out[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: RISC-V M-extension semantics from wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] pa, pb, p;
        longint sa, sb;
        logic ovf;
        pa  = (o == 3'd1 || o == 3'd2) ? {{34{a[31]}}, a} : {34'd0, a};
        pb  = (o == 3'd1) ? {{34{b[31]}}, b} : {34'd0, b};
        p   = pa * pb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0:             return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2]) return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: every completed handshake pops one expected {rd, result}.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n) begin
            if (out_valid[0] && out_ready[0]) begin
                if (q0.size() == 0) check("u0_unexpected_out", {27'd0, rd_out[0], result[0]}, 64'd0);
                else begin
                    e = q0.pop_front();
                    check("u0_out", {27'd0, rd_out[0], result[0]}, {27'd0, e});
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                if (q1.size() == 0) check("u1_unexpected_out", {27'd0, rd_out[1], result[1]}, 64'd0);
                else begin
                    e = q1.pop_front();
                    check("u1_out", {27'd0, rd_out[1], result[1]}, {27'd0, e});
                end
            end
        end
    end

    task automatic wait_idle(input int u);
        int n = 0;
        @(negedge clk);
        while (!in_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[u]) check("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic start(input int u, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        wait_idle(u);
        op[u] = o; src_a[u] = a; src_b[u] = b; rd_in[u] = rd; in_valid[u] = 1'b1;
        @(posedge clk);
        #1 in_valid[u] = 1'b0;
    endtask

    task automatic issue(input int u, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        int n;
        int exp_lat;
        wait_idle(u);
        op[u] = o; src_a[u] = a; src_b[u] = b; rd_in[u] = rd; in_valid[u] = 1'b1;
        @(posedge clk);
        if (u == 0) q0.push_back({rd, exp});
        else        q1.push_back({rd, exp});
        #1 in_valid[u] = 1'b0;
        n = 1;
        while (!out_valid[u] && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        exp_lat = (u == 0 && special(o, a, b)) ? 1 : 33;
        check($sformatf("latency_u%0d_op%0d", u, o), 64'(n), 64'(exp_lat));
    endtask

    initial begin
        logic        seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [4:0]  rr;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            flush[u] = 0; in_valid[u] = 0; op[u] = 0; src_a[u] = 0; src_b[u] = 0;
            rd_in[u] = 0; out_ready[u] = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready[0]), 64'd1);
        check("reset_out_valid", 64'(out_valid[0]), 64'd0);
        check("reset_busy", 64'(busy[0]), 64'd0);
        check("reset_result", {27'd0, rd_out[0], result[0]}, 64'd0);
        rst_n = 1'b1;

        issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        issue(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        issue(0, 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC);
        issue(0, 3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1);
        for (int u = 0; u < 2; u++) begin
            issue(u, 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
            issue(u, 3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
            issue(u, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
            issue(u, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
            issue(u, 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFFF);
            issue(u, 3'd0, 32'd0, 32'd1234, 5'd14, 32'd0);
        end

        // Back-pressure in DONE.
        out_ready[0] = 1'b0;
        issue(0, 3'd0, 32'd9, 32'd11, 5'd17, 32'd99);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid[0]), 64'd1);
            check("hold_result", {27'd0, rd_out[0], result[0]}, {27'd0, 5'd17, 32'd99});
            check("hold_ready_busy", {62'd0, in_ready[0], busy[0]}, 64'd1);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 check("after_done_in_ready", 64'(in_ready[0]), 64'd1);

        // flush in IDLE blocks acceptance.
        @(negedge clk);
        in_valid[0] = 1'b1; flush[0] = 1'b1;
        @(posedge clk);
        #1 check("idle_flush_busy", 64'(busy[0]), 64'd0);
        in_valid[0] = 1'b0; flush[0] = 1'b0;

        // flush on BUSY cycle 10.
        start(0, 3'd4, 32'd1000, 32'd7, 5'd20);
        repeat (9) @(posedge clk);
        @(negedge clk) flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        check("flush_in_ready", 64'(in_ready[0]), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (out_valid[0]) seen = 1'b1;
        end
        check("flush_no_out", 64'(seen), 64'd0);

        // Reset mid-BUSY.
        start(0, 3'd0, 32'd123, 32'd456, 5'd21);
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ctrl", {61'd0, in_ready[0], out_valid[0], busy[0]}, 64'd4);
        check("rst_mid_data", {27'd0, rd_out[0], result[0]}, 64'd0);
        rst_n = 1'b1;
        issue(0, 3'd0, 32'd3, 32'd4, 5'd22, 32'd12);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7)); ra = pick(); rb = pick(); rr = 5'($urandom_range(0, 31));
            issue(0, ro, ra, rb, rr, model(ro, ra, rb));
        end
        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 7)); ra = pick(); rb = pick(); rr = 5'($urandom_range(0, 31));
            issue(1, ro, ra, rb, rr, model(ro, ra, rb));
        end

        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        @(negedge clk);
        check("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
